if_id_stage_reg: RTL and testbench
==================================

# if_id_stage_reg

Parametrised IF/ID pipeline stage register for the pipelined RISC-V core. It carries instruction and PC from fetch to decode using a valid/ready handshake, with an optional skid buffer that registers the upstream ready path. A synchronous flush squashes in-flight beats by presenting a canonical NOP bubble. It replaces the fixed-width, always-advancing IF/ID latch, adding stall, backpressure and flush-with-priority behaviour.

## Interface
- INSTR_W, 32, instruction payload width
- PC_W, 32, PC payload width
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), value driven on out_instr when no valid beat
- SKID, 1, 1 = two-entry skid (registered in_ready); 0 = single register with combinational in_ready
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  squash all held beats and the beat offered this cycle (branch/jump redirect)
- out_valid  out  1  beat available to decode
- out_ready  in  1  decode accepts the beat
- out_instr  out  INSTR_W  held instruction, NOP_INSTR when out_valid=0
- out_pc  out  PC_W  held PC, 0 when out_valid=0

## Operation
- fire_in = in_valid & in_ready & ~flush; fire_out = out_valid & out_ready.
- State: main entry (valid, instr, pc); skid entry (valid, instr, pc) only when SKID=1.
- Priority per edge: reset > flush > normal update.
- Reset: main/skid valid=0, out_instr=NOP_INSTR, out_pc=0; in_ready=1 (SKID=1) from first edge after release. Beats offered while resetn=0 are ignored.
- Flush: both valids cleared, out_instr=NOP_INSTR, out_pc=0, concurrent input beat discarded. A beat with fire_out in the flush cycle counts as consumed by decode.
- Normal, SKID=1:
  - main empty or fire_out: if skid valid, main<=skid and skid cleared; else if fire_in, main<=input; else main valid<=0.
  - main full and no fire_out: if fire_in, skid<=input.
  - in_ready(next) = ~skid_valid(next). Registered, with no combinational path from out_ready.
- Normal, SKID=0: in_ready = out_ready | ~out_valid (combinational). main<=input on fire_in; else main valid<=0 on fire_out.
- Ordering is strictly FIFO, with no loss or duplication.
- Payload updates only on load, so held data stays stable while out_valid & ~out_ready.

## Timing
- Latency: 1 cycle, input edge to out_valid, when the stage is empty.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- SKID=1 backpressure: in_ready falls 1 cycle after the skid fills. At most 2 beats are held.
- SKID=1 refill: in_ready rises in the cycle after the skid drains to main.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge. A new beat is accepted in that cycle and appears 1 cycle later.
- All outputs are registered except in_ready in SKID=0 mode.

## Structure
- Shared package if_id_pkg:
  - localparam NOP_INSTR
  - typedef struct packed {instr, pc} if_id_beat_t, sized from package widths for core-wide use.
- Sub-module: pipe_skid_buf, holding the generic valid/ready skid logic on a packed payload, instantiated once.
- if_id_stage_reg wraps pipe_skid_buf and adds the flush/NOP policy and SKID generate.
- Expected size: 150–250 lines total.

## Test plan
- Reset: resetn=0 for 3 cycles with in_valid=1 and in_instr=0xDEADBEEF.
  - Required: out_valid=0, out_instr=0x00000013, out_pc=0.
  - Required: in_ready=1 at first cycle after release; 0xDEADBEEF never appears.
- Stream: out_ready=1, beats pc 0x100/0x104/0x108 on consecutive cycles.
  - Required: each appears exactly 1 cycle later, one per cycle, in order.
- Backpressure (SKID=1): out_ready=0 after beat 0x100 lands, offer 0x104 then 0x108.
  - Required: in_ready=0 from cycle after 0x104 accepted; 0x108 held by source.
  - Then set out_ready=1: required output order 0x100, 0x104, 0x108, no gaps beyond 1 cycle, no duplicates.
- Flush full: main and skid hold 0x200/0x204, flush=1 with in_valid=1 and pc 0x208.
  - Required: next cycle out_valid=0, out_instr=NOP, out_pc=0, in_ready=1.
  - Required: 0x200/0x204/0x208 never appear afterwards.
- Flush vs reset: resetn=0 and flush=1 together.
  - Required: reset values.
  - Then flush alone on an empty stage: required no change and no spurious valid.
- SKID=0 build: drive out_ready low/high.
  - Required: in_ready = out_ready | ~out_valid in the same cycle.
  - Required: 1-beat capacity, ordering preserved.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: default payload widths, the canonical NOP bubble
// and the packed beat type used by fetch/decode and their benches.
package if_id_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_id_beat_t;

  function automatic if_id_beat_t bubble();
    if_id_beat_t b;
    b.instr = NOP_INSTR;
    b.pc    = '0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_stage_reg_if.sv
// Valid/ready beat channel carrying an instruction and its PC.
// The master drives the beat; the slave answers with ready.
interface if_id_stage_reg_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);

  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register on a packed payload, either as a
// two-entry skid (registered in_ready) or a single entry (combinational in_ready).
module pipe_skid_buf #(
  parameter int           W    = 64,
  parameter bit           SKID = 1'b1,
  parameter logic [W-1:0] IDLE = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         fire_in;
  logic         fire_out;

  assign fire_out  = main_valid & out_ready;
  assign fire_in   = in_valid & in_ready & ~clear;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  generate
    if (SKID) begin : g_skid
      logic         skid_valid;
      logic [W-1:0] skid_data;
      logic         ready_q;
      logic         main_valid_nxt;
      logic [W-1:0] main_data_nxt;
      logic         skid_valid_nxt;
      logic [W-1:0] skid_data_nxt;

      // The skid only fills while main stalls, and always drains into main first,
      // so ready can be a plain register of "skid will be empty".
      always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (clear) begin
          main_valid_nxt = 1'b0;
          main_data_nxt  = IDLE;
          skid_valid_nxt = 1'b0;
        end else if (!main_valid || fire_out) begin
          if (skid_valid) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = skid_data;
            skid_valid_nxt = 1'b0;
          end else if (fire_in) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = in_data;
          end else begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = IDLE;
          end
        end else if (fire_in) begin
          skid_valid_nxt = 1'b1;
          skid_data_nxt  = in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          main_valid <= 1'b0;
          main_data  <= IDLE;
          skid_valid <= 1'b0;
          skid_data  <= IDLE;
          ready_q    <= 1'b1;
        end else begin
          main_valid <= main_valid_nxt;
          main_data  <= main_data_nxt;
          skid_valid <= skid_valid_nxt;
          skid_data  <= skid_data_nxt;
          ready_q    <= ~skid_valid_nxt;
        end
      end

      assign in_ready = ready_q;
    end else begin : g_single
      assign in_ready = out_ready | ~main_valid;

      always_ff @(posedge clk) begin
        if (!resetn || clear) begin
          main_valid <= 1'b0;
          main_data  <= IDLE;
        end else if (fire_in) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (fire_out) begin
          main_valid <= 1'b0;
          main_data  <= IDLE;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID stage register: valid/ready handshake between fetch and decode with an
// optional skid, and a flush that squashes everything into a NOP bubble.
module if_id_stage_reg #(
  parameter int                 INSTR_W   = if_id_pkg::INSTR_W,
  parameter int                 PC_W      = if_id_pkg::PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(if_id_pkg::NOP_INSTR),
  parameter bit                 SKID      = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  if_id_stage_reg_if.slave   up,
  if_id_stage_reg_if.master  dn
);

  localparam int           W    = INSTR_W + PC_W;
  // Empty entries hold the bubble so decode sees NOP/0 straight from flops.
  localparam logic [W-1:0] IDLE = {NOP_INSTR, {PC_W{1'b0}}};

  logic [W-1:0] out_data;

  pipe_skid_buf #(
    .W    (W),
    .SKID (SKID),
    .IDLE (IDLE)
  ) u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush),
    .in_valid  (up.valid),
    .in_ready  (up.ready),
    .in_data   ({up.instr, up.pc}),
    .out_valid (dn.valid),
    .out_ready (dn.ready),
    .out_data  (out_data)
  );

  assign dn.instr = out_data[W-1:PC_W];
  assign dn.pc    = out_data[PC_W-1:0];

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: SKID=1 and SKID=0 builds side by side, compared
// every cycle against queue-based FIFO models of capacity 2 and 1.
module tb_if_id_stage_reg;
  import if_id_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  always #5 clk = ~clk;

  if_id_stage_reg_if #(.INSTR_W(32), .PC_W(32)) up1 ();
  if_id_stage_reg_if #(.INSTR_W(32), .PC_W(32)) dn1 ();
  if_id_stage_reg_if #(.INSTR_W(32), .PC_W(32)) up0 ();
  if_id_stage_reg_if #(.INSTR_W(32), .PC_W(32)) dn0 ();

  assign up1.valid = in_valid;
  assign up1.instr = in_instr;
  assign up1.pc    = in_pc;
  assign dn1.ready = out_ready;
  assign up0.valid = in_valid;
  assign up0.instr = in_instr;
  assign up0.pc    = in_pc;
  assign dn0.ready = out_ready;

  if_id_stage_reg #(.SKID(1'b1)) u_dut1 (.clk(clk), .resetn(resetn), .flush(flush), .up(up1), .dn(dn1));
  if_id_stage_reg #(.SKID(1'b0)) u_dut0 (.clk(clk), .resetn(resetn), .flush(flush), .up(up0), .dn(dn0));

  // Reference: each stage is a FIFO; skid build holds up to 2 with ready = "fewer than 2 held"
  // as of the last edge, single build holds 1 with ready = out_ready or empty.
  if_id_beat_t q1[$];
  if_id_beat_t q0[$];
  bit          rdy1 = 1'b1;
  int          total = 0;
  int          bad = 0;

  logic [65:0] obs1;
  logic [65:0] obs0;
  assign obs1 = {dn1.valid, dn1.instr, dn1.pc, up1.ready};
  assign obs0 = {dn0.valid, dn0.instr, dn0.pc, up0.ready};

  function automatic logic [65:0] exp1();
    if_id_beat_t h;
    h = (q1.size() > 0) ? q1[0] : bubble();
    return {q1.size() > 0, h, rdy1};
  endfunction

  function automatic logic [65:0] exp0();
    if_id_beat_t h;
    bit v;
    v = q0.size() > 0;
    h = v ? q0[0] : bubble();
    return {v, h, out_ready | ~v};
  endfunction

  task automatic cycle();
    bit fin1, fout1, fin0, fout0;
    if_id_beat_t b;
    fout1 = (q1.size() > 0) && out_ready;
    fin1  = in_valid && rdy1 && !flush;
    fout0 = (q0.size() > 0) && out_ready;
    fin0  = in_valid && (out_ready || q0.size() == 0) && !flush;
    b.instr = in_instr;
    b.pc    = in_pc;
    @(posedge clk);
    if (!resetn || flush) begin
      q1.delete();
      q0.delete();
      rdy1 = 1'b1;
    end else begin
      if (fout1) void'(q1.pop_front());
      if (fin1) q1.push_back(b);
      rdy1 = q1.size() < 2;
      if (fout0) void'(q0.pop_front());
      if (fin0) q0.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 32'hDEAD0000;
    repeat (3) cycle();
    total++;
    if (dn1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dn1.valid); end
    total++;
    if (dn1.instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", dn1.instr); end
    total++;
    if (dn1.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", dn1.pc); end
    resetn = 1'b1; in_valid = 1'b0;
    #1;
    total++;
    if (up1.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", up1.ready); end
    total++;
    if (obs0 !== exp0()) begin bad++; $display("FAIL reset_noskid got=%h exp=%h", obs0, exp0()); end
    cycle();
    total++;
    if (obs1 !== exp1()) begin bad++; $display("FAIL reset_after got=%h exp=%h", obs1, exp1()); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_pc    = 32'h100 + 32'(4 * i);
      in_instr = $urandom;
      #1;
      total++;
      if (obs1 !== exp1()) begin bad++; $display("FAIL stream_skid got=%h exp=%h", obs1, exp1()); end
      total++;
      if (obs0 !== exp0()) begin bad++; $display("FAIL stream_noskid got=%h exp=%h", obs0, exp0()); end
      if (i >= 1 && i <= 3) begin
        total++;
        if (dn1.valid !== 1'b1 || dn1.pc !== 32'h100 + 32'(4 * (i - 1)))
          begin bad++; $display("FAIL stream_order got v=%b pc=%h exp pc=%h", dn1.valid, dn1.pc, 32'h100 + 32'(4 * (i - 1))); end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs[3];
    logic [31:0] seen[$];
    int idx;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    in_valid = 1'b1; in_pc = pcs[0]; in_instr = $urandom; out_ready = 1'b1;
    #1;
    cycle();
    in_pc = pcs[1]; in_instr = $urandom; out_ready = 1'b0;
    #1;
    cycle();
    idx = 2;
    for (int k = 0; k < 10; k++) begin
      in_valid  = (idx < 3);
      in_pc     = (idx < 3) ? pcs[idx] : 32'h0;
      if (k == 0) in_instr = $urandom;
      out_ready = (k >= 2);
      #1;
      total++;
      if (obs1 !== exp1()) begin bad++; $display("FAIL bp_skid got=%h exp=%h", obs1, exp1()); end
      total++;
      if (obs0 !== exp0()) begin bad++; $display("FAIL bp_noskid got=%h exp=%h", obs0, exp0()); end
      if (k == 0) begin
        total++;
        if (up1.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", up1.ready); end
      end
      if (dn1.valid && out_ready) seen.push_back(dn1.pc);
      if (in_valid && rdy1) idx++;
      cycle();
    end
    total++;
    if (seen.size() != 3 || seen[0] !== pcs[0] || seen[1] !== pcs[1] || seen[2] !== pcs[2])
      begin bad++; $display("FAIL bp_order got n=%0d seen=%p exp 100,104,108", seen.size(), seen); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h200; in_instr = $urandom; #1; cycle();
    in_pc = 32'h204; in_instr = $urandom; #1; cycle();
    total++;
    if (obs1 !== exp1()) begin bad++; $display("FAIL flush_full_pre got=%h exp=%h", obs1, exp1()); end
    flush = 1'b1; in_pc = 32'h208; in_instr = $urandom;
    #1;
    cycle();
    flush = 1'b0; in_valid = 1'b1; in_pc = 32'h20C; in_instr = $urandom; out_ready = 1'b1;
    #1;
    total++;
    if (dn1.valid !== 1'b0 || dn1.instr !== 32'h0000_0013 || dn1.pc !== 32'h0 || up1.ready !== 1'b1)
      begin bad++; $display("FAIL flush_bubble got v=%b i=%h pc=%h rdy=%b exp 0/00000013/0/1", dn1.valid, dn1.instr, dn1.pc, up1.ready); end
    total++;
    if (obs0 !== exp0()) begin bad++; $display("FAIL flush_noskid got=%h exp=%h", obs0, exp0()); end
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 0) begin
        total++;
        if (dn1.valid !== 1'b1 || dn1.pc !== 32'h20C)
          begin bad++; $display("FAIL flush_refill got v=%b pc=%h exp v=1 pc=20c", dn1.valid, dn1.pc); end
      end
      total++;
      if (obs1 !== exp1()) begin bad++; $display("FAIL flush_after got=%h exp=%h", obs1, exp1()); end
      cycle();
    end
  endtask

  task automatic test_flush_vs_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = $urandom;
    #1; cycle();
    resetn = 1'b0; flush = 1'b1; in_pc = 32'h304;
    #1; cycle();
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (dn1.valid !== 1'b0 || dn1.instr !== 32'h0000_0013 || dn1.pc !== 32'h0 || up1.ready !== 1'b1)
      begin bad++; $display("FAIL fvr_reset got v=%b i=%h pc=%h rdy=%b exp 0/00000013/0/1", dn1.valid, dn1.instr, dn1.pc, up1.ready); end
    cycle();
    flush = 1'b1;
    #1; cycle();
    flush = 1'b0;
    #1;
    total++;
    if (dn1.valid !== 1'b0 || dn0.valid !== 1'b0 || up1.ready !== 1'b1)
      begin bad++; $display("FAIL fvr_empty_flush got v1=%b v0=%b rdy=%b exp 0/0/1", dn1.valid, dn0.valid, up1.ready); end
    total++;
    if (obs0 !== exp0()) begin bad++; $display("FAIL fvr_noskid got=%h exp=%h", obs0, exp0()); end
    cycle();
  endtask

  task automatic test_noskid();
    logic [31:0] sent[$];
    logic [31:0] seen[$];
    logic [31:0] pc;
    bit acc;
    pc = 32'h400;
    for (int k = 0; k < 50; k++) begin
      in_valid  = (k < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (k < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pc     = pc;
      in_instr  = $urandom;
      #1;
      total++;
      if (obs0 !== exp0()) begin bad++; $display("FAIL noskid_cycle got=%h exp=%h", obs0, exp0()); end
      total++;
      if (obs1 !== exp1()) begin bad++; $display("FAIL noskid_skidref got=%h exp=%h", obs1, exp1()); end
      if (dn0.valid && out_ready) seen.push_back(dn0.pc);
      acc = in_valid && (out_ready || q0.size() == 0);
      if (acc) begin sent.push_back(pc); pc = pc + 32'd4; end
      cycle();
    end
    total++;
    if (seen != sent) begin bad++; $display("FAIL noskid_order got n=%0d exp n=%0d", seen.size(), sent.size()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      resetn    = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      #1;
      total++;
      if (obs1 !== exp1()) begin bad++; $display("FAIL random_skid k=%0d got=%h exp=%h", k, obs1, exp1()); end
      total++;
      if (obs0 !== exp0()) begin bad++; $display("FAIL random_noskid k=%0d got=%h exp=%h", k, obs0, exp0()); end
      cycle();
    end
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_vs_reset();
    test_noskid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
